comutador_bomba: RTL and testbench
==================================

// Module: comutador_bomba
// PURPOSE
//   Relay-driver stage downstream of the pool-pump controller. Takes the controller's
//   painel/rede source requests and drives the two power relays.
//   Enforces break-before-make with a programmable dead time.
//   Flags conflicting requests and accumulates per-source run time in clock ticks (seconds at 1 Hz).
// PARAMETERS
//   DEAD_TICKS  2  cycles both relays stay open when changing source; legal range >= 1
//   CNT_W       8  width of each saturating run-time counter
// PORTS
//   clk_2        in   1      1 Hz system clock
//   reset        in   1      asynchronous, active-low (0 = reset)
//   req_painel   in   1      controller requests pump on solar panels
//   req_rede     in   1      controller requests pump on mains
//   rele_painel  out  1      panel relay drive
//   rele_rede    out  1      mains relay drive
//   fonte        out  2      current state code (estado_t), for SEG/LED display
//   conflito     out  1      registered; 1 while both requests were high at last edge
//   seg_painel   out  CNT_W  ticks spent in S_PAINEL, saturating
//   seg_rede     out  CNT_W  ticks spent in S_REDE, saturating
// BEHAVIOUR
//   - Reset (reset=0):
//     - Immediately, without waiting for a clock edge: state=S_OFF, all outputs 0, counters 0, dead counter 0.
//     - This applies at any point, including mid-S_DEAD.
//   - Effective request: req_painel wins when both requests are high (panel priority).
//     - conflito <= req_painel & req_rede, every edge.
//   - FSM, registered, 1 cycle latency. Requests are sampled at edge n; the relay changes right after edge n.
//     - S_OFF: eff painel -> S_PAINEL; eff rede -> S_REDE; none -> stay. No dead time out of S_OFF.
//     - S_PAINEL: eff painel -> stay.
//       - Eff rede -> S_DEAD, loading dcnt=DEAD_TICKS.
//       - None -> S_OFF.
//     - S_REDE: eff rede -> stay.
//       - Eff painel -> S_DEAD, loading dcnt=DEAD_TICKS.
//       - None -> S_OFF.
//     - S_DEAD:
//       - If dcnt==1: go to the state of the current eff request (S_PAINEL/S_REDE), or S_OFF if none.
//       - Else dcnt <= dcnt-1.
//       - Requests that change during S_DEAD do not shorten it.
//       - Both relays are open for exactly DEAD_TICKS clock periods.
//   - Relay outputs:
//     - rele_painel = (state==S_PAINEL); rele_rede = (state==S_REDE).
//     - Never both 1, in any cycle or reset sequence.
//   - fonte = state.
//   - Counters:
//     - seg_painel += 1 on every edge where state==S_PAINEL before the edge; same for seg_rede and S_REDE.
//     - Each holds at 2**CNT_W-1 (no wrap).
//     - Cleared only by reset.
//   - dcnt width = $clog2(DEAD_TICKS+1).
// STRUCTURE
//   - Package bomba_pkg:
//     - typedef enum logic [1:0] estado_t {S_OFF=0, S_PAINEL=1, S_REDE=2, S_DEAD=3}.
//     - Shared with the controller for SEG decoding.
//   - Sub-module contador_sat #(W): enable, async active-low clear, saturating increment.
//     - Instantiated twice (painel, rede).
//   - Top: FSM + dead counter + conflito register.
// TESTING (DEAD_TICKS=2, CNT_W=8 unless stated)
//   1. reset=0 with both requests high -> all outputs 0, fonte=0.
//      Release reset, both requests 0 -> stays S_OFF.
//   2. req_painel=1 sampled at edge 1 -> rele_painel=1 after edge 1.
//      Hold 5 edges in S_PAINEL -> seg_painel=5, seg_rede=0.
//   3. In S_PAINEL, req_painel=0 / req_rede=1 at edge k:
//      - Both relays 0 after edge k and after edge k+1.
//      - rele_rede=1 after edge k+2; fonte=3 in between.
//   4. In S_OFF, both requests =1 -> conflito=1, rele_painel=1, rele_rede=0.
//      Drop req_painel -> transition to S_REDE via 2-cycle S_DEAD; conflito=0.
//   5. CNT_W=3, 10 edges in S_PAINEL -> seg_painel=7 and stays 7.
//   6. reset=0 asserted asynchronously mid-S_DEAD:
//      - Outputs 0 and fonte=0 before the next edge.
//      - After release with req_rede=1: direct S_OFF->S_REDE, no dead time.
//   All scenarios: assertion that rele_painel & rele_rede is never 1.

Source files
------------

// File: rtl/bomba_pkg.sv
// Shared state encoding for the pool-pump relay path.
// The controller decodes estado_t for its SEG/LED display.
package bomba_pkg;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_PAINEL = 2'd1,
    S_REDE   = 2'd2,
    S_DEAD   = 2'd3
  } estado_t;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with enable and async active-low clear.
// Holds at all-ones instead of wrapping.
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk_2,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/comutador_bomba.sv
// Relay driver: break-before-make source switch between panel and mains,
// with conflict flag and per-source run-time counters.
module comutador_bomba
  import bomba_pkg::*;
#(
  parameter int DEAD_TICKS = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             req_painel,
  input  logic             req_rede,
  output logic             rele_painel,
  output logic             rele_rede,
  output logic [1:0]       fonte,
  output logic             conflito,
  output logic [CNT_W-1:0] seg_painel,
  output logic [CNT_W-1:0] seg_rede
);

  localparam int DW = $clog2(DEAD_TICKS + 1);

  estado_t       state;
  estado_t       state_nx;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nx;
  logic          eff_p;
  logic          eff_r;

  // Panel wins when both are requested.
  assign eff_p = req_painel;
  assign eff_r = req_rede & ~req_painel;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state    <= S_OFF;
      dcnt     <= '0;
      conflito <= 1'b0;
    end else begin
      state    <= state_nx;
      dcnt     <= dcnt_nx;
      conflito <= req_painel & req_rede;
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    unique case (state)
      S_OFF: begin
        if (eff_p) state_nx = S_PAINEL;
        else if (eff_r) state_nx = S_REDE;
      end
      S_PAINEL: begin
        if (eff_r) begin
          state_nx = S_DEAD;
          dcnt_nx  = DW'(DEAD_TICKS);
        end else if (!eff_p) begin
          state_nx = S_OFF;
        end
      end
      S_REDE: begin
        if (eff_p) begin
          state_nx = S_DEAD;
          dcnt_nx  = DW'(DEAD_TICKS);
        end else if (!eff_r) begin
          state_nx = S_OFF;
        end
      end
      S_DEAD: begin
        // Dead time runs to completion regardless of request changes.
        if (dcnt == DW'(1)) begin
          dcnt_nx = '0;
          if (eff_p) state_nx = S_PAINEL;
          else if (eff_r) state_nx = S_REDE;
          else state_nx = S_OFF;
        end else begin
          dcnt_nx = dcnt - DW'(1);
        end
      end
      default: state_nx = S_OFF;
    endcase
  end

  assign rele_painel = (state == S_PAINEL);
  assign rele_rede   = (state == S_REDE);
  assign fonte       = state;

  contador_sat #(.W(CNT_W)) u_cnt_painel (
    .clk_2 (clk_2),
    .reset (reset),
    .en    (state == S_PAINEL),
    .cnt   (seg_painel)
  );

  contador_sat #(.W(CNT_W)) u_cnt_rede (
    .clk_2 (clk_2),
    .reset (reset),
    .en    (state == S_REDE),
    .cnt   (seg_rede)
  );

endmodule

// File: tb/tb_comutador_bomba.sv
// Directed bench for comutador_bomba: default instance plus a CNT_W=3
// instance for the saturation scenario.
module tb_comutador_bomba;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       req_painel;
  logic       req_rede;
  logic       rele_painel;
  logic       rele_rede;
  logic [1:0] fonte;
  logic       conflito;
  logic [7:0] seg_painel;
  logic [7:0] seg_rede;

  logic       r2_painel;
  logic       r2_rede;
  logic       s_rp;
  logic       s_rr;
  logic [1:0] s_fonte;
  logic       s_conf;
  logic [2:0] s_segp;
  logic [2:0] s_segr;

  int total = 0;
  int bad   = 0;

  always #5 clk_2 = ~clk_2;

  comutador_bomba #(.DEAD_TICKS(2), .CNT_W(8)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .req_painel  (req_painel),
    .req_rede    (req_rede),
    .rele_painel (rele_painel),
    .rele_rede   (rele_rede),
    .fonte       (fonte),
    .conflito    (conflito),
    .seg_painel  (seg_painel),
    .seg_rede    (seg_rede)
  );

  comutador_bomba #(.DEAD_TICKS(2), .CNT_W(3)) dut3 (
    .clk_2       (clk_2),
    .reset       (reset),
    .req_painel  (r2_painel),
    .req_rede    (r2_rede),
    .rele_painel (s_rp),
    .rele_rede   (s_rr),
    .fonte       (s_fonte),
    .conflito    (s_conf),
    .seg_painel  (s_segp),
    .seg_rede    (s_segr)
  );

  always @(negedge clk_2) begin
    assert (!(rele_painel & rele_rede))
      else $error("FAIL overlap dut rele_painel=1 rele_rede=1");
    assert (!(s_rp & s_rr))
      else $error("FAIL overlap dut3 rele_painel=1 rele_rede=1");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_painel = 1'b1;
    req_rede = 1'b1;
    r2_painel = 1'b0;
    r2_rede = 1'b0;
    #3;
    total++;
    if ({rele_painel, rele_rede, fonte, conflito} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs got rp=%b rr=%b f=%0d c=%b want 0",
               rele_painel, rele_rede, fonte, conflito);
    end
    total++;
    if ({seg_painel, seg_rede} !== 16'h0) begin
      bad++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", seg_painel, seg_rede);
    end
    tick(2);
    req_painel = 1'b0;
    req_rede = 1'b0;
    reset = 1'b1;
    tick(2);
    total++;
    if (fonte !== 2'd0 || rele_painel !== 1'b0 || rele_rede !== 1'b0) begin
      bad++;
      $display("FAIL idle_off got f=%0d want 0", fonte);
    end
  endtask

  task automatic test_painel;
    req_painel = 1'b1;
    tick();
    total++;
    if (rele_painel !== 1'b1 || fonte !== 2'd1) begin
      bad++;
      $display("FAIL painel_on got rp=%b f=%0d want 1/1", rele_painel, fonte);
    end
    tick(5);
    total++;
    if (seg_painel !== 8'd5 || seg_rede !== 8'd0) begin
      bad++;
      $display("FAIL painel_cnt got %0d/%0d want 5/0", seg_painel, seg_rede);
    end
  endtask

  task automatic test_dead;
    req_painel = 1'b0;
    req_rede = 1'b1;
    tick();
    total++;
    if (rele_painel !== 1'b0 || rele_rede !== 1'b0 || fonte !== 2'd3) begin
      bad++;
      $display("FAIL dead_k got rp=%b rr=%b f=%0d want 0/0/3",
               rele_painel, rele_rede, fonte);
    end
    tick();
    total++;
    if (rele_painel !== 1'b0 || rele_rede !== 1'b0 || fonte !== 2'd3) begin
      bad++;
      $display("FAIL dead_k1 got rp=%b rr=%b f=%0d want 0/0/3",
               rele_painel, rele_rede, fonte);
    end
    tick();
    total++;
    if (rele_rede !== 1'b1 || fonte !== 2'd2) begin
      bad++;
      $display("FAIL dead_k2 got rr=%b f=%0d want 1/2", rele_rede, fonte);
    end
    total++;
    if (seg_painel !== 8'd6 || seg_rede !== 8'd0) begin
      bad++;
      $display("FAIL dead_cnt got %0d/%0d want 6/0", seg_painel, seg_rede);
    end
  endtask

  task automatic test_conflict;
    req_rede = 1'b0;
    tick();
    total++;
    if (fonte !== 2'd0 || seg_rede !== 8'd1) begin
      bad++;
      $display("FAIL rede_off got f=%0d seg_rede=%0d want 0/1", fonte, seg_rede);
    end
    req_painel = 1'b1;
    req_rede = 1'b1;
    tick();
    total++;
    if (conflito !== 1'b1 || rele_painel !== 1'b1 || rele_rede !== 1'b0) begin
      bad++;
      $display("FAIL conflict got c=%b rp=%b rr=%b want 1/1/0",
               conflito, rele_painel, rele_rede);
    end
    req_painel = 1'b0;
    tick();
    total++;
    if (fonte !== 2'd3 || conflito !== 1'b0) begin
      bad++;
      $display("FAIL conf_dead got f=%0d c=%b want 3/0", fonte, conflito);
    end
    tick();
    total++;
    if (fonte !== 2'd3) begin
      bad++;
      $display("FAIL conf_dead2 got f=%0d want 3", fonte);
    end
    tick();
    total++;
    if (rele_rede !== 1'b1 || fonte !== 2'd2) begin
      bad++;
      $display("FAIL conf_rede got rr=%b f=%0d want 1/2", rele_rede, fonte);
    end
  endtask

  task automatic test_dead_change;
    req_painel = 1'b1;
    req_rede = 1'b0;
    tick();
    req_painel = 1'b0;
    tick();
    total++;
    if (fonte !== 2'd3) begin
      bad++;
      $display("FAIL hold_dead got f=%0d want 3", fonte);
    end
    tick();
    total++;
    if (fonte !== 2'd0 || rele_painel !== 1'b0 || rele_rede !== 1'b0) begin
      bad++;
      $display("FAIL dead_to_off got f=%0d want 0", fonte);
    end
  endtask

  task automatic test_async_reset;
    req_painel = 1'b1;
    tick();
    req_painel = 1'b0;
    req_rede = 1'b1;
    tick();
    total++;
    if (fonte !== 2'd3) begin
      bad++;
      $display("FAIL pre_rst got f=%0d want 3", fonte);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (fonte !== 2'd0 || rele_painel !== 1'b0 || rele_rede !== 1'b0 ||
        conflito !== 1'b0 || seg_painel !== 8'd0 || seg_rede !== 8'd0) begin
      bad++;
      $display("FAIL async_rst got f=%0d rp=%b rr=%b c=%b segs=%0d/%0d want 0",
               fonte, rele_painel, rele_rede, conflito, seg_painel, seg_rede);
    end
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (fonte !== 2'd2 || rele_rede !== 1'b1) begin
      bad++;
      $display("FAIL off_to_rede got f=%0d rr=%b want 2/1", fonte, rele_rede);
    end
    req_rede = 1'b0;
  endtask

  task automatic test_saturate;
    r2_painel = 1'b1;
    tick();
    total++;
    if (s_fonte !== 2'd1 || s_segp !== 3'd0) begin
      bad++;
      $display("FAIL sat_entry got f=%0d seg=%0d want 1/0", s_fonte, s_segp);
    end
    tick(10);
    total++;
    if (s_segp !== 3'd7) begin
      bad++;
      $display("FAIL sat_10 got %0d want 7", s_segp);
    end
    tick(2);
    total++;
    if (s_segp !== 3'd7 || s_segr !== 3'd0) begin
      bad++;
      $display("FAIL sat_hold got %0d/%0d want 7/0", s_segp, s_segr);
    end
    r2_painel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_painel();
    test_dead();
    test_conflict();
    test_dead_change();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
